// File: rtl/shared_inv_sbox_array.sv
// Two-share inverse S-box layer for uBlock decryption: 16 nibble lanes, each
// computing Sinv = G(F(x)) as two registered quadratic stages with guard re-masking.

module inv_sbox_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] a0,
    input  logic [3:0] a1,
    input  logic [9:0] g1,
    input  logic [9:0] g2,
    output logic [3:0] s1_0,
    output logic [3:0] y0,
    output logic [3:0] y1
);
    logic [3:0] s1_1;

    // Own-share slice of x_i*x_j: summed over both shares gives (p_i^q_i)(p_j^q_j).
    function automatic logic xm(input logic pi, input logic pj, input logic qj);
        return (pi & pj) ^ (pi & qj);
    endfunction

    // F: w3 = 1^x1^x2^x3x0^x1x0, w2 = 1^x0^x2^x1x0, w1 = x0^x1^x3^x3x0, w0 = 1^x0
    function automatic logic [3:0] f_sh(input logic [3:0] p, input logic [3:0] q,
                                        input logic k);
        logic [3:0] r;
        r[3] = k ^ p[1] ^ p[2] ^ xm(p[3], p[0], q[0]) ^ xm(p[1], p[0], q[0]);
        r[2] = k ^ p[0] ^ p[2] ^ xm(p[1], p[0], q[0]);
        r[1] = p[0] ^ p[1] ^ p[3] ^ xm(p[3], p[0], q[0]);
        r[0] = k ^ p[0];
        return r;
    endfunction

    // G: y3 = w3^w2w1, y2 = w2, y1 = w1, y0 = w0^w3w2^w2w1
    function automatic logic [3:0] g_sh(input logic [3:0] p, input logic [3:0] q);
        logic [3:0] r;
        r[3] = p[3] ^ xm(p[2], p[1], q[1]);
        r[2] = p[2];
        r[1] = p[1];
        r[0] = p[0] ^ xm(p[3], p[2], q[2]) ^ xm(p[2], p[1], q[1]);
        return r;
    endfunction

    function automatic logic [3:0] gfold(input logic [9:0] g);
        return g[9:6] ^ g[5:2] ^ {g[1:0], g[1:0]};
    endfunction

    // The same guard word lands in both shares, so the unshared value is untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_0 <= '0;
            s1_1 <= '0;
            y0   <= '0;
            y1   <= '0;
        end else if (en) begin
            s1_0 <= f_sh(a0, a1, 1'b1) ^ gfold(g1);
            s1_1 <= f_sh(a1, a0, 1'b0) ^ gfold(g1);
            y0   <= g_sh(s1_0, s1_1) ^ gfold(g2);
            y1   <= g_sh(s1_1, s1_0) ^ gfold(g2);
        end
    end
endmodule

module shared_inv_sbox_array (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] inv_sbox_array_input0,
    input  logic [63:0] inv_sbox_array_input1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] inv_sbox_array_output0,
    output logic [63:0] inv_sbox_array_output1,
    output logic [15:0] blk_cnt
);
    localparam int NUM_LANES = 16;
    localparam int STAGES    = 2;

    logic                        en;
    logic [STAGES:1]             vld_pipe;
    logic [NUM_LANES-1:0][3:0]   in_s0, in_s1, st1_s0, out_s0, out_s1;
    logic [63:0]                 st1_flat;

    assign en        = !out_valid | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];
    assign in_s0     = inv_sbox_array_input0;
    assign in_s1     = inv_sbox_array_input1;
    assign st1_flat  = st1_s0;
    assign inv_sbox_array_output0 = out_s0;
    assign inv_sbox_array_output1 = out_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe <= '0;
        else if (en)
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blk_cnt <= '0;
        else if (out_valid && out_ready)
            blk_cnt <= blk_cnt + 16'd1;
    end

    // Lane n (nibble bits [4n+3:4n]) guards on share-0 bits [4n+63 : 4n+54] mod 64.
    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        logic [9:0] g1, g2;
        for (genvar k = 0; k < 10; k++) begin : g_grd
            assign g1[k] = inv_sbox_array_input0[(4*n+k+54)%64];
            assign g2[k] = st1_flat[(4*n+k+54)%64];
        end
        inv_sbox_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .a0    (in_s0[n]),
            .a1    (in_s1[n]),
            .g1    (g1),
            .g2    (g2),
            .s1_0  (st1_s0[n]),
            .y0    (out_s0[n]),
            .y1    (out_s1[n])
        );
    end
endmodule

// File: doc/shared_inv_sbox_array.md
# shared_inv_sbox_array

Two-share threshold-implementation inverse S-box layer for the uBlock decryption datapath. It is the counterpart of the forward shared S-box array used in encryption. It applies the uBlock inverse S-box to all 16 nibbles of a 64-bit shared state. Each nibble is computed as two quadratic stages with a register between them, and it re-masks using share-0 bits of neighbouring nibbles as guards. A valid/ready handshake wraps a 2-stage stallable pipeline, and the block sits between the inverse linear layer and the round-key XOR of the decryption round.

## Interface
- No parameters. Width is fixed at 64 bits, i.e. 16 nibbles, 2 shares.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input shares valid this cycle
- in_ready  output  1  block accepts input this cycle
- inv_sbox_array_input0  input  64  share 0 of state; nibble 15 = bits [63:60]
- inv_sbox_array_input1  input  64  share 1 of state
- out_valid  output  1  output shares valid
- out_ready  input  1  consumer accepts output
- inv_sbox_array_output0  output  64  share 0 of result
- inv_sbox_array_output1  output  64  share 1 of result
- blk_cnt  output  16  number of output transfers completed, wrapping

## Operation
- Unshared function, per nibble x, as the XOR of both shares. Sinv(0..F) = C,A,E,D,1,F,B,0,7,2,5,4,3,6,9,8. This is the exact inverse of the uBlock S-box 7,4,9,C,B,A,D,8,F,E,1,6,0,3,2,5.
- Per nibble: stage 1 applies shared quadratic F and registers the result as 2 shares × 4 bits. Stage 2 applies shared quadratic G on the stage-1 registers and registers the output. The unshared G∘F must equal Sinv.
- Guards, 10 bits per nibble, use the same mapping as the forward array:
  - Nibble i (i = 0 for the MSB nibble) takes share-0 bits [59−4i : 50−4i] of its stage input, wrapping modulo 64.
  - Nibble 13 uses {bits[7:0], bits[63:62]}.
  - Nibble 14 uses {bits[3:0], bits[63:58]}.
  - Nibble 15 uses bits[63:54].
  - Stage 1 draws guards from inv_sbox_array_input0. Stage 2 draws them from the stage-1 share-0 register.
- Guards are XORed into both shares identically, so the unshared value is unchanged.
- No combinational path may mix share 0 and share 1 of the same input bit within a single output share (non-completeness).
- Pipeline enable: en = !out_valid | out_ready.
  - in_ready = en.
  - Stage-1 data and v1 load on en. Stage-2 data and out_valid load from stage 1 on en.
  - When en = 0, all registers hold.
- v1 loads in_valid & in_ready.
- Data registers load on every en cycle, even for bubbles. This keeps share registers refreshing without data-dependent clock gating.
- blk_cnt increments on out_valid & out_ready. It wraps from FFFF to 0000.

## Timing
- Reset (rst_n low, asynchronous): all share registers = 0, v1 = 0, out_valid = 0, blk_cnt = 0. in_ready = 1 immediately after reset, because out_valid = 0.
- Latency: an input accepted in cycle t appears with out_valid = 1 in cycle t+2 when out_ready stays high.
- Throughput: 1 block per cycle with no bubbles while out_ready = 1.
- Stall: out_valid = 1 and out_ready = 0 gives in_ready = 0. Outputs and stage 1 are frozen. No data is lost or duplicated.
- Simultaneous events:
  - An output transfer and an input accept occur in the same cycle whenever out_ready = 1.
  - A stalled full pipeline resumes in the cycle out_ready rises. The stage-2 word transfers and the stage-1 word moves up in the same edge.
- in_valid = 0 while en = 1 inserts a bubble; out_valid drops two cycles later.
- Reset mid-operation discards both in-flight blocks. No output transfer is reported for them, and blk_cnt returns to 0.
- Outputs come directly from registers; there is no combinational input-to-output path except in_ready from out_valid/out_ready.

## Test plan
- Identity masking: in0 = 0123456789ABCDEF, in1 = 0, one valid beat, out_ready = 1 → at t+2, out0 ^ out1 = CAED1FB072543698 and blk_cnt = 1.
- Random masking: in0 = M, in1 = M ^ 0123456789ABCDEF for 1000 random M, back-to-back → every XOR result = CAED1FB072543698, one result per cycle, blk_cnt = 1000.
- Exhaustive nibble check: all 16 values broadcast into every nibble, e.g. 16 copies of 7, with random shares → every output nibble equals Sinv, e.g. 7 → 0000000000000000.
- Backpressure: stream 5 blocks, hold out_ready = 0 for 4 cycles after the first output → in_ready = 0 during the stall, output words held stable, all 5 results delivered in order, none repeated.
- Reset mid-flight: accept 2 blocks, assert rst_n low before the first output → out_valid = 0, outputs = 0, blk_cnt = 0, in_ready = 1 after release.
- Counter wrap: force 65536 transfers → blk_cnt returns to 0000 on the 65536th transfer.
